// File: rtl/channel_mixer_stereo_pkg.sv
// Shared types and constants for the stereo channel mixer.
package channel_mixer_stereo_pkg;

  localparam int unsigned NUM_CHANNELS_DEF = 9;
  localparam int unsigned OP_OUT_WIDTH_DEF = 13;
  localparam int unsigned SAMPLE_WIDTH_DEF = 16;

  localparam logic [8:0] ADDR_RYT = 9'h0BD;
  localparam logic [8:0] ADDR_C0  = 9'h0C0;

  typedef struct packed {
    logic cnt;
    logic l_en;
    logic r_en;
  } ch_cfg_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_SECOND,
    ST_RD_FIRST,
    ST_ACCUM,
    ST_DONE
  } state_t;

  // Operators are grouped in banks of six: three first operators then three second operators.
  function automatic int unsigned first_op(input int unsigned ch);
    return (ch / 3) * 6 + (ch % 3);
  endfunction

  function automatic int unsigned second_op(input int unsigned ch);
    return first_op(ch) + 3;
  endfunction

endpackage

// File: rtl/channel_mixer_stereo_if.sv
// Register, operator-result and sample bus of the stereo channel mixer.
interface channel_mixer_stereo_if
  import channel_mixer_stereo_pkg::*;
#(
  parameter int unsigned NUM_CHANNELS = NUM_CHANNELS_DEF,
  parameter int unsigned OP_OUT_WIDTH = OP_OUT_WIDTH_DEF,
  parameter int unsigned SAMPLE_WIDTH = SAMPLE_WIDTH_DEF
);
  localparam int unsigned OPN_W = $clog2(2 * NUM_CHANNELS);

  logic                           reg_wr_valid;
  logic [8:0]                     reg_wr_address;
  logic [7:0]                     reg_wr_data;
  logic                           op_out_valid;
  logic [OPN_W-1:0]               op_out_num;
  logic signed [OP_OUT_WIDTH-1:0] op_out;
  logic                           ops_done_pulse;
  logic                           sample_clk_en;
  logic                           sample_valid;
  logic signed [SAMPLE_WIDTH-1:0] sample_l;
  logic signed [SAMPLE_WIDTH-1:0] sample_r;

  modport master (
    output reg_wr_valid, reg_wr_address, reg_wr_data,
    output op_out_valid, op_out_num, op_out,
    output ops_done_pulse, sample_clk_en,
    input  sample_valid, sample_l, sample_r
  );

  modport slave (
    input  reg_wr_valid, reg_wr_address, reg_wr_data,
    input  op_out_valid, op_out_num, op_out,
    input  ops_done_pulse, sample_clk_en,
    output sample_valid, sample_l, sample_r
  );

endinterface

// File: rtl/channel_mixer_stereo_op_mem.sv
// Single-bank operator result memory: one write port, one read port with 1-cycle latency.
module channel_mixer_stereo_op_mem #(
  parameter int unsigned DEPTH  = 18,
  parameter int unsigned DATA_W = 13,
  parameter int unsigned ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic [DATA_W-1:0] o_rd_data
);
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rd_data;

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < int'(DEPTH); i++) r_mem[i] <= '0;
      r_rd_data <= '0;
    end else begin
      if (i_wr_en && (32'(i_wr_addr) < DEPTH)) r_mem[i_wr_addr] <= i_wr_data;
      r_rd_data <= (32'(i_rd_addr) < DEPTH) ? r_mem[i_rd_addr] : '0;
    end
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/channel_mixer_stereo_saturate.sv
// Combinational signed clamp of a wide accumulator into one output sample.
module stereo_saturate #(
  parameter int unsigned IN_W  = 19,
  parameter int unsigned OUT_W = 16
) (
  input  logic signed [IN_W-1:0]  i_val,
  output logic signed [OUT_W-1:0] o_sat_c
);
  localparam logic signed [IN_W-1:0] MAX_V = IN_W'({1'b0, {(OUT_W-1){1'b1}}});
  localparam logic signed [IN_W-1:0] MIN_V = ~MAX_V;

  always_comb begin
    o_sat_c = i_val[OUT_W-1:0];
    if (i_val > MAX_V)      o_sat_c = MAX_V[OUT_W-1:0];
    else if (i_val < MIN_V) o_sat_c = MIN_V[OUT_W-1:0];
  end

endmodule

// File: rtl/channel_mixer_stereo.sv
// Sums 2-op channel outputs into saturated left/right samples once per sample period.
module channel_mixer_stereo
  import channel_mixer_stereo_pkg::*;
#(
  parameter int unsigned NUM_CHANNELS = NUM_CHANNELS_DEF,
  parameter int unsigned OP_OUT_WIDTH = OP_OUT_WIDTH_DEF,
  parameter int unsigned SAMPLE_WIDTH = SAMPLE_WIDTH_DEF,
  parameter bit          RHYTHM_EN    = 1'b1,
  parameter bit          STEREO       = 1'b1,
  parameter logic [8:0]  REG_BASE_C0  = ADDR_C0
) (
  input logic clk,
  input logic reset,
  channel_mixer_stereo_if.slave bus
);
  localparam int unsigned OPN_W    = $clog2(2 * NUM_CHANNELS);
  localparam int unsigned CH_W     = $clog2(NUM_CHANNELS);
  localparam int unsigned CH_OUT_W = OP_OUT_WIDTH + 2;
  localparam int unsigned ACC_W    = CH_OUT_W + CH_W;

  state_t                         r_state, w_next;
  ch_cfg_t                        r_cfg [NUM_CHANNELS];
  ch_cfg_t                        w_cfg;
  logic                           r_ryt;
  logic [CH_W-1:0]                r_ch;
  logic signed [OP_OUT_WIDTH-1:0] r_op2, w_rd_data;
  logic signed [ACC_W-1:0]        r_acc_l, r_acc_r;
  logic signed [SAMPLE_WIDTH-1:0] r_sample_l, r_sample_r, w_sat_l, w_sat_r;
  logic                           r_sample_valid;
  logic [OPN_W-1:0]               w_rd_addr;
  logic                           w_latch_op2, w_accum, w_done, w_last;
  logic signed [CH_OUT_W-1:0]     w_op1_x, w_op2_x, w_sum, w_ch_out;

  channel_mixer_stereo_op_mem #(
    .DEPTH (2 * NUM_CHANNELS),
    .DATA_W(OP_OUT_WIDTH),
    .ADDR_W(OPN_W)
  ) u_op_mem (
    .clk      (clk),
    .reset    (reset),
    .i_wr_en  (bus.op_out_valid),
    .i_wr_addr(bus.op_out_num),
    .i_wr_data(bus.op_out),
    .i_rd_addr(w_rd_addr),
    .o_rd_data(w_rd_data)
  );

  assign w_last = (32'(r_ch) == NUM_CHANNELS - 1);
  assign w_cfg  = r_cfg[r_ch];

  // Next state and per-cycle datapath strobes; sample_clk_en overrides everything.
  always_comb begin
    w_next      = r_state;
    w_rd_addr   = '0;
    w_latch_op2 = 1'b0;
    w_accum     = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      ST_IDLE:      if (bus.ops_done_pulse) w_next = ST_RD_SECOND;
      ST_RD_SECOND: begin
        w_rd_addr = OPN_W'(second_op(32'(r_ch)));
        w_next    = ST_RD_FIRST;
      end
      ST_RD_FIRST:  begin
        w_rd_addr   = OPN_W'(first_op(32'(r_ch)));
        w_latch_op2 = 1'b1;
        w_next      = ST_ACCUM;
      end
      ST_ACCUM:     begin
        w_accum = 1'b1;
        w_next  = w_last ? ST_DONE : ST_RD_SECOND;
      end
      ST_DONE:      begin
        w_done = 1'b1;
        w_next = ST_IDLE;
      end
      default:      w_next = ST_IDLE;
    endcase
    if (bus.sample_clk_en) begin
      w_next  = ST_IDLE;
      w_accum = 1'b0;
      w_done  = 1'b0;
    end
  end

  // Channel output: read data is op1 during ACCUM, op2 was latched a cycle earlier.
  always_comb begin
    w_op1_x  = CH_OUT_W'(w_rd_data);
    w_op2_x  = CH_OUT_W'(r_op2);
    w_sum    = w_op1_x + w_op2_x;
    w_ch_out = w_cfg.cnt ? w_sum : w_op2_x;
    if (RHYTHM_EN && r_ryt) begin
      if (32'(r_ch) == 6)                           w_ch_out = w_op2_x <<< 1;
      else if (32'(r_ch) == 7 || 32'(r_ch) == 8)    w_ch_out = w_sum <<< 1;
    end
  end

  stereo_saturate #(.IN_W(ACC_W), .OUT_W(SAMPLE_WIDTH)) u_sat_l (.i_val(r_acc_l), .o_sat_c(w_sat_l));
  stereo_saturate #(.IN_W(ACC_W), .OUT_W(SAMPLE_WIDTH)) u_sat_r (.i_val(r_acc_r), .o_sat_c(w_sat_r));

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state        <= ST_IDLE;
      r_ryt          <= 1'b0;
      r_ch           <= '0;
      r_op2          <= '0;
      r_acc_l        <= '0;
      r_acc_r        <= '0;
      r_sample_l     <= '0;
      r_sample_r     <= '0;
      r_sample_valid <= 1'b0;
      for (int c = 0; c < int'(NUM_CHANNELS); c++)
        r_cfg[c] <= '{cnt: 1'b0, l_en: 1'b1, r_en: 1'b1};
    end else begin
      r_state        <= w_next;
      r_sample_valid <= 1'b0;
      if (bus.reg_wr_valid) begin
        if (bus.reg_wr_address == ADDR_RYT) r_ryt <= bus.reg_wr_data[5];
        for (int c = 0; c < int'(NUM_CHANNELS); c++)
          if (bus.reg_wr_address == REG_BASE_C0 + 9'(c))
            r_cfg[c] <= '{cnt: bus.reg_wr_data[0], l_en: bus.reg_wr_data[4], r_en: bus.reg_wr_data[5]};
      end
      if (r_state == ST_IDLE) r_ch <= '0;
      else if (w_accum)       r_ch <= r_ch + CH_W'(1);
      if (w_latch_op2) r_op2 <= w_rd_data;
      if (w_done) begin
        r_sample_l     <= w_sat_l;
        r_sample_r     <= w_sat_r;
        r_sample_valid <= 1'b1;
        r_acc_l        <= '0;
        r_acc_r        <= '0;
      end else if (bus.sample_clk_en) begin
        r_acc_l <= '0;
        r_acc_r <= '0;
      end else if (w_accum) begin
        if (w_cfg.l_en || !STEREO) r_acc_l <= r_acc_l + ACC_W'(w_ch_out);
        if (w_cfg.r_en || !STEREO) r_acc_r <= r_acc_r + ACC_W'(w_ch_out);
      end
    end
  end

  assign bus.sample_valid = r_sample_valid;
  assign bus.sample_l     = r_sample_l;
  assign bus.sample_r     = r_sample_r;

endmodule

// File: tb/tb_channel_mixer_stereo.sv
// Directed scoreboard bench for channel_mixer_stereo (9 channels, stereo, rhythm enabled).
module tb_channel_mixer_stereo;
  localparam int N = 9;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  channel_mixer_stereo_if bus ();

  channel_mixer_stereo dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  typedef struct {
    int l;
    int r;
    int cyc;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fails  = 0;
  int   ncyc     = 0;

  task automatic check(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every sample_valid pops one expectation (values and arrival cycle).
  always @(negedge clk) begin
    exp_t e;
    ncyc++;
    if (bus.sample_valid === 1'b1) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fails++;
        $display("FAIL unexpected_valid: got sample_valid at cycle %0d, expected none", ncyc);
      end else begin
        e = sb.pop_front();
        check("latency", ncyc, e.cyc);
        check("sample_l", bus.sample_l, e.l);
        check("sample_r", bus.sample_r, e.r);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_reg(input int addr, input int data);
    bus.reg_wr_valid   = 1'b1;
    bus.reg_wr_address = 9'(addr);
    bus.reg_wr_data    = 8'(data);
    step();
    bus.reg_wr_valid   = 1'b0;
  endtask

  task automatic wr_op(input int num, input int val);
    bus.op_out_valid = 1'b1;
    bus.op_out_num   = 5'(num);
    bus.op_out       = 13'(val);
    step();
    bus.op_out_valid = 1'b0;
  endtask

  task automatic all_ops(input int val);
    for (int i = 0; i < 2 * N; i++) wr_op(i, val);
  endtask

  task automatic all_cfg(input int data);
    for (int c = 0; c < N; c++) wr_reg('hC0 + c, data);
  endtask

  // Expected sample_valid at the negedge 3*N+2 cycles after the pulse cycle.
  task automatic start_pass(input int l, input int r);
    exp_t e;
    e.l = l;
    e.r = r;
    e.cyc = ncyc + 1 + 3 * N + 2;
    sb.push_back(e);
    bus.ops_done_pulse = 1'b1;
    step();
    bus.ops_done_pulse = 1'b0;
  endtask

  task automatic pulse_only();
    bus.ops_done_pulse = 1'b1;
    step();
    bus.ops_done_pulse = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && sb.size() != 0; i++) step();
    check("drain", sb.size(), 0);
    repeat (3) step();
  endtask

  initial begin
    bus.reg_wr_valid   = 1'b0;
    bus.reg_wr_address = '0;
    bus.reg_wr_data    = '0;
    bus.op_out_valid   = 1'b0;
    bus.op_out_num     = '0;
    bus.op_out         = '0;
    bus.ops_done_pulse = 1'b0;
    bus.sample_clk_en  = 1'b0;

    // Reset with sample_clk_en and ops_done activity.
    step();
    bus.sample_clk_en  = 1'b1;
    bus.ops_done_pulse = 1'b1;
    step();
    bus.sample_clk_en  = 1'b0;
    step();
    bus.ops_done_pulse = 1'b0;
    check("reset_l", bus.sample_l, 0);
    check("reset_r", bus.sample_r, 0);
    check("reset_valid", bus.sample_valid, 0);
    reset = 1'b1;
    step();

    // All CNT=1 L=R=1, ops=100; write to channel 9 address must be ignored.
    all_cfg('h31);
    wr_reg('hC9, 'h00);
    all_ops(100);
    start_pass(1800, 1800);
    drain();

    // Ch0 left only CNT=0, ch1 right only CNT=0.
    all_ops(0);
    wr_op(0, 50);
    wr_op(3, 200);
    wr_op(1, 77);
    wr_op(4, 300);
    wr_reg('hC0, 'h10);
    wr_reg('hC1, 'h20);
    start_pass(200, 300);
    drain();

    // Rhythm mode, CNT=0 everywhere.
    wr_reg('hBD, 'h20);
    all_cfg('h30);
    all_ops(1000);
    start_pass(16000, 16000);
    drain();

    // Rhythm mode, CNT=1: ch0..5 2000, ch6 2000, ch7/8 4000.
    all_cfg('h31);
    start_pass(22000, 22000);
    drain();

    // Saturation at both ends.
    wr_reg('hBD, 'h00);
    all_ops(4095);
    start_pass(32767, 32767);
    drain();
    all_ops(-4096);
    start_pass(-32768, -32768);
    drain();

    // sample_clk_en mid-pass aborts; outputs hold.
    all_ops(100);
    pulse_only();
    repeat (9) step();
    bus.sample_clk_en = 1'b1;
    step();
    bus.sample_clk_en = 1'b0;
    repeat (35) step();
    check("abort_hold_l", bus.sample_l, -32768);
    check("abort_hold_r", bus.sample_r, -32768);

    // sample_clk_en in the same cycle as ops_done drops the pulse.
    bus.sample_clk_en  = 1'b1;
    bus.ops_done_pulse = 1'b1;
    step();
    bus.sample_clk_en  = 1'b0;
    bus.ops_done_pulse = 1'b0;
    repeat (35) step();
    check("drop_hold_l", bus.sample_l, -32768);

    start_pass(1800, 1800);
    drain();

    // Reset mid-pass: no valid, outputs cleared, config and operator memory cleared.
    pulse_only();
    repeat (5) step();
    reset = 1'b0;
    step();
    check("midreset_l", bus.sample_l, 0);
    check("midreset_r", bus.sample_r, 0);
    reset = 1'b1;
    repeat (35) step();
    start_pass(0, 0);
    drain();
    all_ops(100);
    start_pass(900, 900);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
